// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch stage. It holds the PC register and drives the
//   instruction-memory address. A DEPTH-entry queue of {npc, instr} pairs sits
//   in front of decode. Decode pops the head through a valid/ready handshake.
//   A taken branch or jump (pcsrc) reloads the PC and flushes the queue.
//
// Ports
//   clk            in   clock; all state changes on the rising edge
//   reset          in   asynchronous, active-low reset
//   pcsrc          in   redirect request; highest priority
//   branch_target  in   redirect address; bits [1:0] are forced to zero
//   imem_addr      out  instruction-memory address (always equal to pc_out)
//   imem_rdata     in   combinational instruction read at imem_addr
//   pc_out         out  current fetch PC
//   ifid_valid     out  queue head holds an entry that decode may take
//   ifid_ready     in   decode accepts the head this cycle
//   ifid_instr     out  instruction at the queue head
//   ifid_npc       out  PC+PC_STEP of the head instruction
//   q_count        out  queue occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pcsrc,
  input  logic [ADDR_W-1:0]        branch_target,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_rdata,
  output logic [ADDR_W-1:0]        pc_out,
  output logic                     ifid_valid,
  input  logic                     ifid_ready,
  output logic [DATA_W-1:0]        ifid_instr,
  output logic [ADDR_W-1:0]        ifid_npc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] npc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  entry_t            storage [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] pc_next_seq;
  logic              full;
  logic              pop;
  logic              push;

  // The low two target bits only matter for alignment and are dropped.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target[1:0];

  assign pc_next_seq = pc + ADDR_W'(PC_STEP);
  assign full        = (count == CNT_W'(DEPTH));

  // No entry is offered during a redirect cycle. Its contents belong to the
  // path that is being abandoned.
  assign ifid_valid = (count != '0) && !pcsrc;
  assign pop        = ifid_valid && ifid_ready;
  // A full queue can still take a new entry when the head leaves in the same
  // cycle. This is what gives one instruction per cycle at full throughput.
  assign push       = !pcsrc && (!full || pop);

  assign pc_out     = pc;
  assign imem_addr  = pc;
  assign q_count    = count;
  assign ifid_instr = storage[rd_ptr].instr;
  assign ifid_npc   = storage[rd_ptr].npc;

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (pcsrc) begin
      pc     <= {branch_target[ADDR_W-1:2], 2'b00};
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        pc     <= pc_next_seq;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is reset on purpose. The head outputs are read
  // straight from storage, so they must show zero while in reset instead of
  // stale data. This gives up the option of a reset-less RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (push) begin
      storage[wr_ptr] <= '{npc: pc_next_seq, instr: imem_rdata};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Self-checking bench for fetch_queue. A queue-based reference model of the
//   fetch stage is compared with the DUT on every cycle. Literal checks at key
//   points of the directed sequence pin the model itself.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int STEP   = 4;

  typedef struct {
    logic [ADDR_W-1:0] npc;
    logic [DATA_W-1:0] instr;
  } m_entry_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    pcsrc;
  logic [ADDR_W-1:0]       branch_target;
  logic [ADDR_W-1:0]       imem_addr;
  logic [DATA_W-1:0]       imem_rdata;
  logic [ADDR_W-1:0]       pc_out;
  logic                    ifid_valid;
  logic                    ifid_ready;
  logic [DATA_W-1:0]       ifid_instr;
  logic [ADDR_W-1:0]       ifid_npc;
  logic [$clog2(DEPTH):0]  q_count;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  m_entry_t          mq[$];
  logic [ADDR_W-1:0] mpc;

  fetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .RESET_PC('0), .PC_STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset), .pcsrc(pcsrc), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .ifid_valid(ifid_valid), .ifid_ready(ifid_ready), .ifid_instr(ifid_instr),
    .ifid_npc(ifid_npc), .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hCAFE_0000 ^ a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // One clock cycle. Outputs are compared at the falling edge, where they are
  // settled. The model then advances as the DUT will at the next rising edge.
  // Stimulus changes 1 time unit after each rising edge.
  task automatic cycle();
    logic m_valid, m_pop, m_push;
    @(negedge clk);
    if (!reset) begin
      mq.delete();
      mpc = '0;
    end
    m_valid = (mq.size() != 0) && !pcsrc && reset;
    check("pc_out",     pc_out,    mpc);
    check("imem_addr",  imem_addr, mpc);
    check("q_count",    32'(q_count), 32'(mq.size()));
    check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
    check("valid_rule", 32'(ifid_valid), 32'((q_count != 0) && !pcsrc));
    if (m_valid) begin
      check("ifid_instr", ifid_instr, mq[0].instr);
      check("ifid_npc",   ifid_npc,   mq[0].npc);
    end
    if (reset) begin
      if (pcsrc) begin
        mq.delete();
        mpc = {branch_target[ADDR_W-1:2], 2'b00};
      end else begin
        m_pop  = m_valid && ifid_ready;
        m_push = (mq.size() < DEPTH) || m_pop;
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back('{npc: mpc + STEP, instr: mem_word(mpc)});
          mpc = mpc + STEP;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; pcsrc = 1'b0; branch_target = '0; ifid_ready = 1'b0;
    mpc = '0;
    @(posedge clk);
    #1;
    check("rst_pc",    pc_out, 32'h0);
    check("rst_count", 32'(q_count), 32'd0);
    check("rst_valid", 32'(ifid_valid), 32'd0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_npc",   ifid_npc, 32'h0);
    reset = 1'b1;

    // Fill with decode stalled
    repeat (4) cycle();
    check("fill_count", 32'(q_count), 32'd4);
    check("fill_pc",    pc_out, 32'h10);
    check("fill_instr", ifid_instr, 32'hCAFE_0000);
    check("fill_npc",   ifid_npc, 32'h4);
    cycle();
    check("full_hold_pc", pc_out, 32'h10);

    // Full queue with one pop
    ifid_ready = 1'b1;
    cycle();
    ifid_ready = 1'b0;
    check("fullpop_count", 32'(q_count), 32'd4);
    check("fullpop_pc",    pc_out, 32'h14);
    check("fullpop_instr", ifid_instr, 32'hCAFE_0004);

    // Steady stream; the pointers wrap twice
    ifid_ready = 1'b1;
    repeat (8) cycle();
    check("stream_pc",    pc_out, 32'h34);
    check("stream_count", 32'(q_count), 32'd4);
    check("stream_instr", ifid_instr, 32'hCAFE_0024);

    // Redirect with an unaligned target
    pcsrc = 1'b1; branch_target = 32'h43;
    #1;
    check("redir_valid_now", 32'(ifid_valid), 32'd0);
    cycle();
    pcsrc = 1'b0; ifid_ready = 1'b0;
    check("redir_pc",    pc_out, 32'h40);
    check("redir_count", 32'(q_count), 32'd0);
    cycle();
    check("redir_head_valid", 32'(ifid_valid), 32'd1);
    check("redir_head_instr", ifid_instr, 32'hCAFE_0040);
    check("redir_head_npc",   ifid_npc, 32'h44);

    // Back-to-back redirects: the last one wins
    pcsrc = 1'b1; branch_target = 32'h80;
    cycle();
    branch_target = 32'hC0;
    cycle();
    pcsrc = 1'b0;
    check("b2b_pc",    pc_out, 32'hC0);
    check("b2b_count", 32'(q_count), 32'd0);

    // Asynchronous reset mid-run with three entries queued
    repeat (3) cycle();
    check("pre_rst_count", 32'(q_count), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("async_rst_pc",    pc_out, 32'h0);
    check("async_rst_count", 32'(q_count), 32'd0);
    check("async_rst_valid", 32'(ifid_valid), 32'd0);
    cycle();
    reset = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      pcsrc         = ($urandom_range(0, 9) == 0);
      branch_target = $urandom();
      ifid_ready    = ($urandom_range(0, 3) != 0);
      reset         = ($urandom_range(0, 79) != 0);
      cycle();
    end
    reset = 1'b1; pcsrc = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
